// File: rtl/types_pkg.sv
// Shared types for the pole/zero response datapath.
//   flags_t         : per-sample valid/sof/eol sideband carried alongside results
//   pz_seq_state_e  : control states of the sequential pole/zero difference stage
//   sat_resize()    : clip a signed value to a signed field of 'width' bits,
//                     reporting whether clipping happened
package types_pkg;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pz_seq_state_e;

  // Result is returned at 64 bits; the caller narrows it to 'width'.
  function automatic logic signed [63:0] sat_resize(input logic signed [63:0] acc,
                                                    input int unsigned width,
                                                    output logic sat);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    sat = 1'b0;
    sat_resize = acc;
    if (acc > hi) begin
      sat = 1'b1;
      sat_resize = hi;
    end else if (acc < lo) begin
      sat = 1'b1;
      sat_resize = lo;
    end
  endfunction

endpackage

// File: rtl/pz_lane_sum.sv
// Masked partial sum of one ACCUM cycle of the sequential pole/zero stage.
//   zeros/poles : LANES terms each, holding term indices base .. base+LANES-1
//   base        : term index of lane 0
//   nz/np       : active zero/pole counts; a lane whose index is >= its count adds 0
//   psum        : sum(active zeros) - sum(active poles), sign-extended to ACC_W
module pz_lane_sum #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 2,
  parameter int CW         = 4,
  parameter int ACC_W      = 20
) (
  input  logic [LANES-1:0][DATA_WIDTH-1:0] zeros,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] poles,
  input  logic [CW-1:0]                    base,
  input  logic [CW-1:0]                    nz,
  input  logic [CW-1:0]                    np,
  output logic signed [ACC_W-1:0]          psum
);

  always_comb begin
    psum = '0;
    for (int l = 0; l < LANES; l++) begin
      if ((base + CW'(l)) < nz) psum = psum + ACC_W'($signed(zeros[l]));
      if ((base + CW'(l)) < np) psum = psum - ACC_W'($signed(poles[l]));
    end
  end

endmodule

// File: rtl/pz_difference_seq.sv
// Sequential pole/zero difference: sum(zeros[0..nz-1]) - sum(poles[0..np-1]),
// LANES zero terms and LANES pole terms per ACCUM cycle.
//   clk, reset : clock, asynchronous active-high reset
//   in_data    : [0..MAX_PZ-1] zeros, [MAX_PZ..2*MAX_PZ-1] poles
//   num_zeros  : active zero count (clamped to MAX_PZ)
//   num_poles  : active pole count (clamped to MAX_PZ)
//   flags_in   : sample flags; valid && in_ready is the accept handshake
//   in_ready   : a sample can be accepted this cycle
//   diff_out   : signed result, held until out_ready
//   flags_out  : flags of diff_out; valid = result held
//   sat_out    : result was clipped (PZ_SAT_EN builds only, otherwise 0)
//   out_ready  : consumer accepts diff_out
// Build option: define PZ_SAT_EN to saturate the result to OUT_WIDTH; without it
// the result wraps modulo 2^OUT_WIDTH.
module pz_difference_seq
  import types_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_PZ     = 8,
  parameter int LANES      = 2,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [2*MAX_PZ-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic [$clog2(MAX_PZ):0]              num_zeros,
  input  logic [$clog2(MAX_PZ):0]              num_poles,
  input  flags_t                               flags_in,
  output logic                                 in_ready,
  output logic [OUT_WIDTH-1:0]                 diff_out,
  output flags_t                               flags_out,
  output logic                                 sat_out,
  input  logic                                 out_ready
);

  localparam int CW    = $clog2(MAX_PZ) + 1;
  localparam int ACC_W = DATA_WIDTH + $clog2(MAX_PZ) + 1;

  pz_seq_state_e state, state_nxt;

  logic [2*MAX_PZ-1:0][DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]                       nz_q, np_q, base, span;
  logic                                sof_q, eol_q;
  logic signed [ACC_W-1:0]             acc, psum, acc_nxt;
  logic [LANES-1:0][DATA_WIDTH-1:0]    z_lane, p_lane;
  logic                                hs, last;
  logic [OUT_WIDTH-1:0]                res;
  logic                                res_sat;

  function automatic logic [CW-1:0] clamp(input logic [CW-1:0] c);
    return (c > CW'(MAX_PZ)) ? CW'(MAX_PZ) : c;
  endfunction

  assign hs      = flags_in.valid && in_ready;
  assign span    = (nz_q > np_q) ? nz_q : np_q;
  // Last cycle once this window reaches the longer list; span==0 still gives one cycle.
  assign last    = ({1'b0, base} + (CW+1)'(LANES)) >= {1'b0, span};
  assign acc_nxt = acc + psum;

  // Window mux: base is a multiple of LANES below MAX_PZ, so every index stays in range.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CW-1:0] zi, pi;
    assign zi        = base + CW'(l);
    assign pi        = zi + CW'(MAX_PZ);
    assign z_lane[l] = data_q[zi];
    assign p_lane[l] = data_q[pi];
  end

  pz_lane_sum #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .CW         (CW),
    .ACC_W      (ACC_W)
  ) u_lane_sum (
    .zeros (z_lane),
    .poles (p_lane),
    .base  (base),
    .nz    (nz_q),
    .np    (np_q),
    .psum  (psum)
  );

`ifdef PZ_SAT_EN
  always_comb begin
    res_sat = 1'b0;
    res     = OUT_WIDTH'(sat_resize(64'(acc_nxt), OUT_WIDTH, res_sat));
  end
`else
  assign res     = OUT_WIDTH'(acc_nxt);
  assign res_sat = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = ACCUM;
      ACCUM:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = hs ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs of the FSM
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;
  end

  // Capture, accumulate and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      nz_q      <= '0;
      np_q      <= '0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      acc       <= '0;
      base      <= '0;
      diff_out  <= '0;
      flags_out <= '0;
      sat_out   <= 1'b0;
    end else begin
      if (hs) begin
        data_q <= in_data;
        nz_q   <= clamp(num_zeros);
        np_q   <= clamp(num_poles);
        sof_q  <= flags_in.sof;
        eol_q  <= flags_in.eol;
        acc    <= '0;
        base   <= '0;
      end else if (state == ACCUM) begin
        acc  <= acc_nxt;
        base <= base + CW'(LANES);
      end
      if (state == ACCUM && last) begin
        diff_out  <= res;
        sat_out   <= res_sat;
        flags_out <= '{valid: 1'b1, sof: sof_q, eol: eol_q};
      end else if (state == DONE && out_ready && !hs) begin
        // A back-to-back accept keeps valid up while the next sample accumulates.
        flags_out.valid <= 1'b0;
      end
    end
  end

endmodule
